// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl
//   Sponge sequencer for a Keccak-f[1600] datapath. It carries no data. It
//   tracks the rate-lane index, gates absorption of input-stream words, inserts
//   the SHA-3 padding lanes, kicks the permutation core, and sequences the
//   squeeze onto the output stream.
//
//   Optional feature: define KECCAK_CTRL_WDOG_EN to build the stall watchdog.
//   Without it, stall_timeout is tied low.
//
// Ports
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   s_tvalid/s_tlast/s_tready  input stream handshake
//   absorb_en                datapath XORs lane lane_idx with data or pad constant
//   pad_first / pad_last     pad constant select (0x06 in byte 0 / 0x80 in byte 7)
//   lane_idx                 current rate lane
//   state_clr                one-cycle pulse: zero the 1600-bit state
//   perm_start / perm_done   permutation core handshake pulses
//   m_tvalid/m_tlast/m_tready  output stream handshake (data = state lane lane_idx)
//   busy                     FSM not idle
//   stall_timeout            sticky watchdog flag
module keccak_sponge_ctrl #(
    parameter int RATE_WORDS  = 17,
    parameter int OUT_WORDS   = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       absorb_en,
    output logic       pad_first,
    output logic       pad_last,
    output logic [4:0] lane_idx,
    output logic       state_clr,
    output logic       perm_start,
    input  logic       perm_done,
    output logic       m_tvalid,
    output logic       m_tlast,
    input  logic       m_tready,
    output logic       busy,
    output logic       stall_timeout
);

    localparam logic [4:0] LAST_LANE = 5'(RATE_WORDS - 1);
    localparam logic [4:0] LAST_OUT  = 5'(OUT_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PERM,
        ST_PAD,
        ST_SQUEEZE
    } state_t;

    state_t     state, nxt_state;
    logic [4:0] nxt_lane;
    logic       pend_pad, nxt_pend;
    logic       final_blk, nxt_final;
    logic       s_hs, m_hs;

    // The cycle carrying state_clr is spent in ABSORB without accepting a
    // word, so the clear never coincides with the first absorb XOR.
    assign s_tready  = (state == ST_ABSORB) && !state_clr;
    assign s_hs      = s_tready && s_tvalid;
    assign absorb_en = s_hs || (state == ST_PAD);
    assign m_hs      = m_tvalid && m_tready;

    always_comb begin
        nxt_state = state;
        nxt_lane  = lane_idx;
        nxt_pend  = pend_pad;
        nxt_final = final_blk;
        case (state)
            ST_IDLE: begin
                nxt_lane = 5'd0;
                if (s_tvalid) nxt_state = ST_ABSORB;
            end
            ST_ABSORB: begin
                if (s_hs) begin
                    if (lane_idx == LAST_LANE) begin
                        // A tlast on the final rate lane leaves no room for
                        // padding: it goes into a fresh block after this perm.
                        nxt_lane  = 5'd0;
                        nxt_state = ST_PERM;
                        nxt_pend  = s_tlast;
                    end else begin
                        nxt_lane = lane_idx + 5'd1;
                        if (s_tlast) nxt_state = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (lane_idx == LAST_LANE) begin
                    nxt_lane  = 5'd0;
                    nxt_state = ST_PERM;
                    nxt_pend  = 1'b0;
                    nxt_final = 1'b1;
                end else begin
                    nxt_lane = lane_idx + 5'd1;
                end
            end
            ST_PERM: begin
                nxt_lane = 5'd0;
                if (perm_done) begin
                    if (pend_pad)       nxt_state = ST_PAD;
                    else if (final_blk) nxt_state = ST_SQUEEZE;
                    else                nxt_state = ST_ABSORB;
                end
            end
            ST_SQUEEZE: begin
                if (m_tready) begin
                    if (lane_idx == LAST_OUT) begin
                        nxt_lane  = 5'd0;
                        nxt_state = ST_IDLE;
                        nxt_final = 1'b0;
                    end else begin
                        nxt_lane = lane_idx + 5'd1;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next-state decode so they line up with
    // the cycle in which the FSM occupies the corresponding state.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= ST_IDLE;
            lane_idx   <= 5'd0;
            pend_pad   <= 1'b0;
            final_blk  <= 1'b0;
            state_clr  <= 1'b0;
            perm_start <= 1'b0;
            pad_first  <= 1'b0;
            pad_last   <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt_state;
            lane_idx   <= nxt_lane;
            pend_pad   <= nxt_pend;
            final_blk  <= nxt_final;
            state_clr  <= (state == ST_IDLE) && s_tvalid;
            perm_start <= (nxt_state == ST_PERM) && (state != ST_PERM);
            pad_first  <= (nxt_state == ST_PAD) && (state != ST_PAD);
            pad_last   <= (nxt_state == ST_PAD) && (nxt_lane == LAST_LANE);
            m_tvalid   <= (nxt_state == ST_SQUEEZE);
            m_tlast    <= (nxt_state == ST_SQUEEZE) && (nxt_lane == LAST_OUT);
            busy       <= (nxt_state != ST_IDLE);
        end
    end

`ifdef KECCAK_CTRL_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              progress;

    assign progress = s_hs || m_hs || perm_done;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wdog_cnt      <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!busy || progress)     wdog_cnt <= '0;
            else if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WDOG_MAX)  stall_timeout <= 1'b1;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog   = ^WDOG_CYCLES ^ m_hs;
    assign stall_timeout = 1'b0;
`endif

endmodule
